// File: rtl/zintack.sv
// zintack: Z80 interrupt-acknowledge and RETI detector.
// Synchronizes the asynchronous Z80 strobes and drives the IM2 vector
// during acknowledge. It pulses reti when an ED 4D opcode pair is fetched
// and counts the acknowledge cycles it has seen.
module zintack (
    input  logic       clk,
    input  logic       res_n,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic [7:0] din,
    input  logic [7:0] im2vect,
    output logic       intack,
    output logic [7:0] vout,
    output logic       vout_oe,
    output logic       reti,
    output logic [7:0] ack_cnt
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} ack_state_t;
    typedef enum logic       {R_IDLE, R_ED}    reti_state_t;

    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_4D = 8'h4D;

    // Strobe vector order: {m1_n, iorq_n, mreq_n, rd_n}
    logic [3:0]  strb_p0, strb_p1;
    logic        s_m1_n, s_iorq_n, s_mreq_n, s_rd_n;
    logic [7:0]  din_p0, din_p1, fetch_byte;
    logic        f, f_p1, fetch_done;
    ack_state_t  ack_state, ack_state_nx;
    logic        ack_start;
    reti_state_t reti_state, reti_state_nx;
    logic        reti_nx;

    assign s_m1_n   = strb_p1[3];
    assign s_iorq_n = strb_p1[2];
    assign s_mreq_n = strb_p1[1];
    assign s_rd_n   = strb_p1[0];

    // Two-flop synchronizers; reset to the inactive (high) level
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            strb_p0 <= 4'b1111;
            strb_p1 <= 4'b1111;
        end else begin
            strb_p0 <= {m1_n, iorq_n, mreq_n, rd_n};
            strb_p1 <= strb_p0;
        end
    end

    // Data delay matching the synchronizer depth; capture the opcode while fetching
    always_ff @(posedge clk) begin
        din_p0 <= din;
        din_p1 <= din_p0;
        if (f) fetch_byte <= din_p1;
    end

    // An IORQ together with M1 is an acknowledge and never a fetch, even when MREQ is also low
    assign f          = !s_m1_n && !s_mreq_n && !s_rd_n && s_iorq_n;
    assign fetch_done = f_p1 && !f;

    // Previous-cycle fetch strobe for falling-edge detection
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) f_p1 <= 1'b0;
        else        f_p1 <= f;
    end

    // Acknowledge FSM state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) ack_state <= IDLE;
        else        ack_state <= ack_state_nx;
    end

    // Acknowledge FSM next-state; HOLD must return to IDLE before a new ACK
    always_comb begin
        ack_state_nx = ack_state;
        ack_start    = 1'b0;
        case (ack_state)
            IDLE: if (!s_m1_n && !s_iorq_n) begin
                ack_state_nx = ACK;
                ack_start    = 1'b1;
            end
            ACK:  ack_state_nx = HOLD;
            HOLD: if (s_iorq_n || s_m1_n) ack_state_nx = IDLE;
            default: ack_state_nx = IDLE;
        endcase
    end

    // Latch the vector and count on entry to ACK only
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vout    <= 8'h00;
            ack_cnt <= 8'h00;
        end else if (ack_start) begin
            vout    <= im2vect;
            ack_cnt <= ack_cnt + 8'd1;
        end
    end

    assign intack  = (ack_state != IDLE);
    assign vout_oe = intack;

    // RETI FSM state and registered pulse
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            reti_state <= R_IDLE;
            reti       <= 1'b0;
        end else begin
            reti_state <= reti_state_nx;
            reti       <= reti_nx;
        end
    end

    // RETI FSM next-state; only completed M1 opcode fetches advance it
    always_comb begin
        reti_state_nx = reti_state;
        reti_nx       = 1'b0;
        if (fetch_done) begin
            case (reti_state)
                R_IDLE: if (fetch_byte == OP_ED) reti_state_nx = R_ED;
                R_ED: begin
                    if (fetch_byte == OP_ED) begin
                        reti_state_nx = R_ED;
                    end else begin
                        reti_state_nx = R_IDLE;
                        reti_nx       = (fetch_byte == OP_4D);
                    end
                end
                default: reti_state_nx = R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zintack.sv
// Bench for zintack: directed Z80 bus sequences with a scoreboard of
// expected acknowledge and RETI events, checked by a negedge monitor.
module tb_zintack;

    logic       clk = 1'b0;
    logic       res_n = 1'b1;
    logic       m1_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1;
    logic [7:0] din = 8'h00, im2vect = 8'h00;
    logic       intack, vout_oe, reti;
    logic [7:0] vout, ack_cnt;

    typedef struct {
        bit         is_reti;
        logic [7:0] vec;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt = 8'h00;
    logic [7:0] cur_vec = 8'h00;
    logic       intack_d = 1'b0;
    logic       reti_d = 1'b0;

    zintack dut (
        .clk(clk), .res_n(res_n), .m1_n(m1_n), .iorq_n(iorq_n),
        .mreq_n(mreq_n), .rd_n(rd_n), .din(din), .im2vect(im2vect),
        .intack(intack), .vout(vout), .vout_oe(vout_oe), .reti(reti),
        .ack_cnt(ack_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (res_n) begin
            chk("oe_eq_intack", {7'd0, vout_oe}, {7'd0, intack});
            if (intack && !intack_d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 8'h01, 8'h00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_kind", {7'd0, e.is_reti}, 8'h00);
                    chk("ack_vout", vout, e.vec);
                    chk("ack_cnt", ack_cnt, e.cnt);
                    cur_vec = e.vec;
                end
            end else if (intack) begin
                chk("vout_hold", vout, cur_vec);
            end
            if (reti) begin
                chk("reti_width", {7'd0, reti_d}, 8'h00);
                if (sb.size() == 0) begin
                    chk("unexpected_reti", 8'h01, 8'h00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("reti_kind", {7'd0, e.is_reti}, 8'h01);
                end
            end
        end
        intack_d = intack;
        reti_d   = reti;
    end

    task automatic push_reti();
        exp_t e;
        e.is_reti = 1'b1; e.vec = 8'h00; e.cnt = 8'h00;
        sb.push_back(e);
    endtask

    task automatic push_ack(input logic [7:0] vec);
        exp_t e;
        exp_cnt   = exp_cnt + 8'd1;
        e.is_reti = 1'b0; e.vec = vec; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic do_ack(input logic [7:0] vec, input int hold, input bit illegal,
                          input logic [7:0] newvec);
        @(negedge clk);
        im2vect = vec;
        push_ack(vec);
        m1_n = 1'b0; iorq_n = 1'b0;
        if (illegal) begin mreq_n = 1'b0; rd_n = 1'b0; end
        @(posedge clk); @(posedge clk); #1;
        chk("ack_latency_lo", {7'd0, intack}, 8'h00);
        @(posedge clk); #1;
        chk("ack_latency_hi", {7'd0, intack}, 8'h01);
        im2vect = newvec;
        repeat (hold - 3) @(posedge clk);
        @(negedge clk);
        m1_n = 1'b1; iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("ack_tail", {7'd0, intack}, 8'h01);
        @(posedge clk); #1;
        chk("ack_drop", {7'd0, intack}, 8'h00);
        repeat (2) @(posedge clk);
    endtask

    // m1 = 0 gives an opcode fetch, m1 = 1 a plain memory read
    task automatic bus_read(input logic [7:0] b, input logic m1);
        @(negedge clk);
        m1_n = m1; mreq_n = 1'b0; rd_n = 1'b0; din = b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; din = 8'h00;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #2 res_n = 1'b0;
        #1;
        chk("rst_intack", {7'd0, intack}, 8'h00);
        chk("rst_oe", {7'd0, vout_oe}, 8'h00);
        chk("rst_vout", vout, 8'h00);
        chk("rst_reti", {7'd0, reti}, 8'h00);
        chk("rst_cnt", ack_cnt, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk) res_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic acknowledge with FD
        do_ack(8'hFD, 6, 1'b0, 8'hFD);
        #1 chk("cnt_after_first", ack_cnt, 8'h01);

        // ED 4D -> one pulse
        bus_read(8'hED, 1'b0); push_reti(); bus_read(8'h4D, 1'b0);
        // ED ED 4D -> one pulse
        bus_read(8'hED, 1'b0); bus_read(8'hED, 1'b0); push_reti(); bus_read(8'h4D, 1'b0);
        // ED 00 4D -> none
        bus_read(8'hED, 1'b0); bus_read(8'h00, 1'b0); bus_read(8'h4D, 1'b0);
        // ED, non-M1 read of 4D (ignored), then 4D fetch -> one pulse
        bus_read(8'hED, 1'b0); bus_read(8'h4D, 1'b1); push_reti(); bus_read(8'h4D, 1'b0);
        // ED, acknowledge in between (ignored by RETI), then 4D -> one pulse
        bus_read(8'hED, 1'b0); do_ack(8'h12, 4, 1'b0, 8'h12); push_reti(); bus_read(8'h4D, 1'b0);

        // Illegal M1+MREQ+IORQ is an acknowledge, not a fetch
        bus_read(8'hED, 1'b0);
        din = 8'h4D;
        do_ack(8'h34, 4, 1'b1, 8'h34);
        din = 8'h00;
        bus_read(8'h00, 1'b0);

        // Vector change during HOLD is ignored
        do_ack(8'hFF, 6, 1'b0, 8'hFB);

        // Reset during HOLD
        @(negedge clk);
        im2vect = 8'h77; push_ack(8'h77);
        m1_n = 1'b0; iorq_n = 1'b0;
        repeat (5) @(posedge clk);
        #3 res_n = 1'b0;
        #1;
        chk("midrst_oe", {7'd0, vout_oe}, 8'h00);
        chk("midrst_intack", {7'd0, intack}, 8'h00);
        chk("midrst_cnt", ack_cnt, 8'h00);
        chk("midrst_vout", vout, 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        exp_cnt = 8'h00;
        @(negedge clk) res_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("no_spurious_ack", {7'd0, intack}, 8'h00);

        // Reset released with acknowledge still active: synchronizer latency applies
        @(negedge clk);
        res_n = 1'b0;
        m1_n = 1'b0; iorq_n = 1'b0; im2vect = 8'h44;
        #2;
        exp_cnt = 8'h00;
        push_ack(8'h44);
        res_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_sync_lat_lo", {7'd0, intack}, 8'h00);
        @(posedge clk); #1;
        chk("rst_sync_lat_hi", {7'd0, intack}, 8'h01);
        @(negedge clk);
        m1_n = 1'b1; iorq_n = 1'b1;
        repeat (5) @(posedge clk);

        // 256 acknowledges from reset wrap the counter
        @(negedge clk) res_n = 1'b0;
        exp_cnt = 8'h00;
        @(negedge clk) res_n = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            do_ack(i[7:0], 3, 1'b0, i[7:0]);
        end
        #1 chk("cnt_wrap", ack_cnt, 8'h00);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sb.size() > 0 ? 8'h01 : 8'h00, 8'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/zintack.md
ZINTACK -- requirements
Module: zintack

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 res_n  in  1  asynchronous active-low reset.
REQ-003 m1_n  in  1  Z80 M1, asynchronous to clk.
REQ-004 iorq_n  in  1  Z80 IORQ, asynchronous to clk.
REQ-005 mreq_n  in  1  Z80 MREQ, asynchronous to clk.
REQ-006 rd_n  in  1  Z80 RD, asynchronous to clk.
REQ-007 din  in  8  Z80 data bus as seen by the CPU (opcode fetch data).
REQ-008 im2vect  in  8  IM2 vector from the interrupt controller.
REQ-009 intack  out  1  level, high for the whole acknowledge cycle.
REQ-010 vout  out  8  vector driven to the data bus during acknowledge.
REQ-011 vout_oe  out  1  data-bus drive enable for vout.
REQ-012 reti  out  1  one-clk pulse on completed RETI (ED 4D) fetch.
REQ-013 ack_cnt  out  8  wrapping count of acknowledge cycles since reset.

Function
REQ-014 m1_n, iorq_n, mreq_n, rd_n SHALL each pass a 2-FF synchronizer; all decoding uses the synchronized copies (s_*).
REQ-015 din SHALL pass a 2-stage register delay so it stays aligned with the synchronized strobes.
REQ-016 Acknowledge FSM states: IDLE, ACK, HOLD.
REQ-017 IDLE->ACK when s_m1_n=0 and s_iorq_n=0; in that same clk, im2vect is latched into vout.
REQ-018 ACK->HOLD unconditionally after 1 clk.
REQ-019 HOLD->IDLE when s_iorq_n=1 or s_m1_n=1.
REQ-020 intack=1 and vout_oe=1 in ACK and HOLD; both are 0 in IDLE.
REQ-021 vout SHALL hold the latched value through ACK/HOLD; im2vect changes during ACK/HOLD are ignored.
REQ-022 ack_cnt SHALL increment by 1 on each IDLE->ACK transition and wrap FF->00.
REQ-023 Opcode fetch strobe f = !s_m1_n & !s_mreq_n & !s_rd_n; a fetch completes on the clk where f falls (1 to 0).
REQ-024 The aligned din SHALL be sampled at the last clk with f=1.
REQ-025 RETI FSM states: R_IDLE, R_ED.
REQ-026 R_IDLE->R_ED on a completed fetch with byte ED.
REQ-027 In R_ED, a completed fetch with 4D pulses reti for 1 clk and goes to R_IDLE.
REQ-028 In R_ED, a completed fetch with ED stays in R_ED.
REQ-029 In R_ED, any other completed fetch goes to R_IDLE with no pulse.
REQ-030 Non-M1 reads (operand or data reads) SHALL NOT affect the RETI FSM.
REQ-031 An acknowledge cycle (M1 with IORQ, no MREQ) is not a fetch; RETI FSM state is unchanged.
REQ-032 Simultaneous m1_n=0, mreq_n=0, iorq_n=0 (illegal) SHALL be treated as acknowledge; no fetch completes.
REQ-033 Back-to-back acknowledges SHALL require a return to IDLE between them; each is counted once.

Reset
REQ-034 On res_n=0, immediately and independent of clk: intack=0, vout_oe=0, vout=00, reti=0, ack_cnt=00.
REQ-035 On res_n=0, both FSMs go to IDLE/R_IDLE and synchronizers load 1 (inactive).
REQ-036 Reset asserted mid-acknowledge SHALL drop vout_oe at once; after release, a still-active m1_n/iorq_n starts a new ACK only after synchronizer latency (2 clks).

Verification
REQ-037 im2vect=FD, m1_n=iorq_n=0 for 6 clks -> intack/vout_oe high from clk 3 until 2 clks after release, vout=FD, ack_cnt=01.
REQ-038 Fetches ED, 4D -> single reti pulse after the second fetch ends; fetches ED, ED, 4D -> one pulse; ED, 00, 4D -> none.
REQ-039 ED fetch, then a memory read of 4D with m1_n=1 -> no reti.
REQ-040 256 acknowledge cycles -> ack_cnt wraps to 00.
REQ-041 res_n low during HOLD -> vout_oe=0 same cycle; ack_cnt=00; no spurious ACK after release while inputs are idle.
REQ-042 im2vect changes FF->FB during HOLD -> vout stays FF.
